// File: rtl/ef_i2s_tdm_rx.sv
// I2S / left-justified / TDM master receiver: generates sck/ws, captures MSB-first slots,
// formats each capture and queues it with its slot number in a first-word-fall-through FIFO.
module ef_i2s_tdm_rx #(
  parameter int NCH     = 2,
  parameter int FIFO_AW = 4,
  parameter int PRESC_W = 8,
  localparam int CHW    = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [PRESC_W-1:0] sck_prescaler,
  input  logic [4:0]         sample_size,
  input  logic               sign_extend,
  input  logic [NCH-1:0]     ch_mask,
  output logic               sck,
  output logic               ws,
  input  logic               sdi,
  input  logic               fifo_rd,
  output logic [31:0]        fifo_rdata,
  output logic [CHW-1:0]     fifo_rch,
  output logic               fifo_empty,
  output logic               fifo_full,
  output logic [FIFO_AW:0]   fifo_level,
  input  logic [FIFO_AW:0]   fifo_threshold,
  output logic               fifo_level_above,
  output logic               overrun,
  input  logic               clr_overrun
);

  typedef enum logic [1:0] {
    MODE_I2S = 2'd0,
    MODE_LJ  = 2'd1,
    MODE_TDM = 2'd2,
    MODE_ALT = 2'd3
  } mode_t;

  localparam int unsigned DEPTH      = 2 ** FIFO_AW;
  localparam int unsigned FRAME_BITS = NCH * 32;
  localparam int unsigned HALF_CH    = NCH / 2;

  mode_t              mode_e;
  logic [PRESC_W-1:0] presc;
  logic [4:0]         bcnt;
  logic [CHW-1:0]     scnt;
  logic [31:0]        shreg;
  logic               first_frame;

  logic               tick, rise, fall;
  logic               last_bit, last_slot;
  logic [4:0]         bnext;
  logic [CHW-1:0]     snext;
  logic               ws_next, ws_idle;
  logic [31:0]        word;
  logic               push;

  assign mode_e    = mode_t'(mode);
  assign tick      = en && (presc == '0);
  assign rise      = tick && !sck;
  assign fall      = tick && sck;
  assign last_bit  = (bcnt == 5'd31);
  assign last_slot = (scnt == CHW'(NCH - 1));
  assign bnext     = bcnt + 5'd1;
  assign snext     = last_bit ? (last_slot ? '0 : scnt + CHW'(1)) : scnt;
  assign ws_idle   = (mode_e != MODE_TDM);

  // ws is computed for the (slot, bit) being entered, so it is valid for the whole bit period
  always_comb begin
    int unsigned pos;
    pos     = (32'(snext) * 32 + 32'(bnext) + 1) % FRAME_BITS;
    ws_next = 1'b0;
    case (mode_e)
      MODE_LJ:  ws_next = (32'(snext) >= HALF_CH);
      MODE_TDM: ws_next = (snext == CHW'(NCH - 1)) && (bnext == 5'd31);
      default:  ws_next = (pos >= FRAME_BITS / 2);
    endcase
  end

  // Bits above N-1 in shreg are stale leftovers from earlier slots, so they are replaced here
  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i <= 32'(sample_size))
        word[i] = shreg[i];
      else
        word[i] = sign_extend & shreg[sample_size];
    end
  end

  assign push = fall && last_bit && ch_mask[scnt] && !first_frame;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc       <= sck_prescaler;
      sck         <= 1'b0;
      ws          <= 1'b1;
      bcnt        <= '0;
      scnt        <= '0;
      shreg       <= '0;
      first_frame <= 1'b1;
    end else if (!en) begin
      presc       <= sck_prescaler;
      sck         <= 1'b0;
      ws          <= ws_idle;
      bcnt        <= '0;
      scnt        <= '0;
      first_frame <= 1'b1;
    end else begin
      presc <= tick ? sck_prescaler : presc - PRESC_W'(1);
      if (rise) begin
        sck <= 1'b1;
        if (bcnt <= sample_size)
          shreg <= {shreg[30:0], sdi};
      end
      if (fall) begin
        sck  <= 1'b0;
        bcnt <= bnext;
        scnt <= snext;
        ws   <= ws_next;
        if (last_bit && last_slot)
          first_frame <= 1'b0;
      end
    end
  end

  logic [31:0]        mem_data [DEPTH];
  logic [CHW-1:0]     mem_ch   [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic               wr_ok, rd_ok;
  logic [FIFO_AW:0]   level_next;

  assign rd_ok      = fifo_rd && !fifo_empty;
  assign wr_ok      = push && (!fifo_full || rd_ok);
  assign level_next = fifo_level + (FIFO_AW + 1)'(wr_ok) - (FIFO_AW + 1)'(rd_ok);

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem_data[wptr] <= word;
      mem_ch[wptr]   <= scnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (wr_ok)
        wptr <= wptr + FIFO_AW'(1);
      if (rd_ok)
        rptr <= rptr + FIFO_AW'(1);
      fifo_level <= level_next;
      fifo_empty <= (level_next == '0);
      fifo_full  <= (level_next == (FIFO_AW + 1)'(DEPTH));
      if (push && fifo_full && !rd_ok)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;
    end
  end

  assign fifo_rdata       = mem_data[rptr];
  assign fifo_rch         = mem_ch[rptr];
  assign fifo_level_above = (fifo_level > fifo_threshold);

endmodule

// File: doc/ef_i2s_tdm_rx.md
# ef_i2s_tdm_rx

Parametrised I2S/TDM master receiver, successor to the two-channel I2S receiver. Generates `sck`/`ws` from the system clock and frames `NCH` 32-bit slots per frame in I2S, left-justified or TDM (DSP) mode. Captures a programmable number of MSB-first bits per slot and formats each capture as a right-aligned, optionally sign-extended word. Pushes each word, tagged with its slot number, into a first-word-fall-through FIFO read by the bus wrapper.

## Interface
Parameters:
- `NCH`, 2, channels (slots) per frame; 2..8; must be even in modes 0/1.
- `FIFO_AW`, 4, FIFO depth = 2**FIFO_AW.
- `PRESC_W`, 8, prescaler width.
- `CHW` (localparam) = max(1, clog2(NCH)).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset is synchronous and active-high.
- `en`  in  1  enable; 0 = idle.
- `mode`  in  2  00 I2S, 01 left-justified, 10 TDM, 11 treated as 00.
- `sck_prescaler`  in  PRESC_W  P; sck half-period = P+1 clk.
- `sample_size`  in  5  N-1; N = bits captured per slot (1..32).
- `sign_extend`  in  1  sign-extend from bit N-1.
- `ch_mask`  in  NCH  per-slot push enable.
- `sck`, `ws`  out  1  serial clock, word select / frame sync.
- `sdi`  in  1  serial data.
- `fifo_rd`  in  1  pop one entry.
- `fifo_rdata`  out  32  head sample.
- `fifo_rch`  out  CHW  head slot number.
- `fifo_empty`, `fifo_full`  out  1  flags.
- `fifo_level`  out  FIFO_AW+1  entries held (0..2**FIFO_AW).
- `fifo_threshold`  in  FIFO_AW+1; `fifo_level_above`  out  1  = level > threshold.
- `overrun`  out  1  sticky; `clr_overrun`  in  1  clears it.

## Operation
- Prescaler: while `en`, counts P down to 0, then reloads P. Tick = `en` and prescaler==0.
- Rise tick (tick, sck=0): `sck` toggles to 1; `sdi` is sampled in this same cycle.
- Fall tick (tick, sck=1): `sck` toggles to 0; bit counter b (0..31) advances; it wraps into slot counter s (0..NCH-1), and s wraps at frame end.
- The MSB of slot s always occupies bit period b=0, so capture is mode-independent. `ws` is registered and updated on fall ticks to the value for the new (s,b):
  - mode 0: ws = 1 iff ((s*32+b+1) mod (NCH*32)) >= NCH*16, i.e. one-bit lead.
  - mode 1: ws = 1 iff s >= NCH/2.
  - mode 2: ws = 1 only during s=NCH-1, b=31.
- Capture: on a rise tick with b < N, shift `sdi` into the slot shift register, MSB first.
- Push: on the fall tick ending b=31, if `ch_mask[s]` is set, write {s, word} to the FIFO.
  - word = captured N bits right-aligned.
  - Upper bits are copies of bit N-1 if `sign_extend`, else 0.
  - N=32 passes unchanged.
- First frame after `en` rises: all pushes are suppressed, because the slot-0 framing lacks its lead.
- `en` low: synchronous return to idle in the next cycle.
  - Prescaler reloads to P; `sck`=0; s=b=0.
  - `ws` goes to its idle value: 1 in modes 0/1, 0 in mode 2.
  - The partial slot is discarded; FIFO contents and `overrun` are retained.
- Config inputs must be static while `en`=1.
- FIFO (first-word fall-through):
  - Read while empty: ignored.
  - Write while full without read: data dropped and `overrun` set.
  - Read and write together while full: both accepted; level unchanged.
  - Read and write together while empty: write accepted, read ignored.
  - If `overrun` set and `clr_overrun` occur in the same cycle, set wins.

## Timing
- Reset values:
  - `sck`=0, `ws`=1, prescaler=P, s=b=0.
  - FIFO empty: `fifo_empty`=1, `fifo_full`=0, `fifo_level`=0, `overrun`=0.
  - `fifo_level_above` = (0 > threshold).
  - `fifo_rdata`/`fifo_rch` undefined while empty.
- Reset has priority over `en` and over all FIFO operations.
- sck period = 2(P+1) clk; frame = NCH*64*(P+1) clk.
- First `sck` rise occurs P+1 clk after `en` is first seen high.
- Push latency: write occurs in the fall-tick cycle ending b=31.
  - The entry is visible on `fifo_rdata`, `fifo_empty` deasserts and the level updates in the next cycle.
- Pop: `fifo_rd` in cycle t updates head, level and flags at t+1.
- All outputs are registered except `fifo_rdata`/`fifo_rch` (array read at the head pointer) and `fifo_level_above` (compare).

## Test plan
- Mode 0, NCH=2, P=1, N=24, sign_extend=1, mask=11, BFM drives L=0x800001, R=0x123456 -> `ws` transitions one sck before each MSB; frame 1 produces no entries; then entries {0,0xFF800001}, {1,0x00123456} repeat per frame; sck period 4 clk.
- Mode 2, NCH=8, mask=0xA5, N=16, sign_extend=0, slot k carries 0x8000+k -> `ws` is one sck wide during s=7 b=31; FIFO order is ch0,2,5,7 with data 0x00008000, 0x00008002, 0x00008005, 0x00008007.
- FIFO_AW=2, no reads, 5 pushes -> level 4, `fifo_full`=1, `overrun`=1, first four entries kept; `clr_overrun` -> 0; `fifo_rd` together with a push at full -> level stays 4, `overrun` stays 0.
- `en` dropped at s=0, b=10 -> next cycle `sck`=0, `ws`=1, no push; re-enable -> counters start at 0 and the first frame is discarded.
- `rst` asserted mid-frame with 3 entries held -> next cycle all outputs are at reset values and level=0; the same check with `en`=1 held shows reset priority.
- Mode 1, N=1 and N=32 corners, threshold=2 -> single-bit 1 with sign_extend yields 0xFFFFFFFF; 32-bit word is unmodified; `fifo_level_above` asserts when the level reaches 3.
